// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bus for wb_regfile: pipeline register outputs,
// ID-stage read ports, forwarding value and retire visibility.
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  logic             RegWrite;
  logic             MemtoReg;
  logic [63:0]      Read_data;
  logic [63:0]      Alu_result;
  logic [4:0]       Write_reg;
  logic [31:0]      Instruction_mem_wb;
  logic [4:0]       read_reg1;
  logic [4:0]       read_reg2;
  logic [63:0]      read_data1;
  logic [63:0]      read_data2;
  logic [63:0]      wb_data;
  logic             wb_valid;
  logic [CNT_W-1:0] retired_count;
  logic [31:0]      last_instr;

  modport master (
    output RegWrite, MemtoReg, Read_data, Alu_result, Write_reg,
           Instruction_mem_wb, read_reg1, read_reg2,
    input  read_data1, read_data2, wb_data, wb_valid, retired_count, last_instr
  );

  modport slave (
    input  RegWrite, MemtoReg, Read_data, Alu_result, Write_reg,
           Instruction_mem_wb, read_reg1, read_reg2,
    output read_data1, read_data2, wb_data, wb_valid, retired_count, last_instr
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32 x 64-bit architectural register file of the LEGv8
// pipeline. Selects the writeback value, commits it, serves two asynchronous
// read ports, and tracks retired instructions.
// Optional feature: define WB_BYPASS_EN to forward the same-cycle writeback
// value onto the read ports (write-before-read); otherwise reads return the
// array contents only.
module wb_regfile #(
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [63:0]      regs_q [32];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      last_q, last_d;
  logic [63:0]      wb_data_w;
  logic             wb_valid_w;
  logic [63:0]      rd1_w, rd2_w;

  // Writeback select and commit qualification (XZR writes are dropped)
  always_comb begin
    wb_data_w  = bus.MemtoReg ? bus.Read_data : bus.Alu_result;
    wb_valid_w = bus.RegWrite && (bus.Write_reg != ZR);
  end

  // Asynchronous read ports; XZR check dominates any bypass
  always_comb begin
    rd1_w = regs_q[bus.read_reg1];
    rd2_w = regs_q[bus.read_reg2];
`ifdef WB_BYPASS_EN
    if (wb_valid_w && (bus.read_reg1 == bus.Write_reg)) rd1_w = wb_data_w;
    if (wb_valid_w && (bus.read_reg2 == bus.Write_reg)) rd2_w = wb_data_w;
`endif
    if (bus.read_reg1 == ZR) rd1_w = '0;
    if (bus.read_reg2 == ZR) rd2_w = '0;
  end

  // Retire tracking: non-bubble instructions count, saturating at all-ones
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (bus.Instruction_mem_wb != 32'h0) begin
      last_d = bus.Instruction_mem_wb;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register array commit; reset clears everything and discards the write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_valid_w) begin
      regs_q[bus.Write_reg] <= wb_data_w;
    end
  end

  // Retire state registers; reset discards a same-cycle retire
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign bus.wb_data       = wb_data_w;
  assign bus.wb_valid      = wb_valid_w;
  assign bus.read_data1    = rd1_w;
  assign bus.read_data2    = rd2_w;
  assign bus.retired_count = cnt_q;
  assign bus.last_instr    = last_q;

endmodule
